// File: rtl/prog_loader_if.sv
// ----------------------------------------------------------------------------
// prog_loader_if -- byte-stream and program-memory bus of the program loader.
//
// Signals
//   in_valid   source -> loader   byte-stream source has data
//   in_data    source -> loader   program byte
//   in_ready   loader -> source   loader accepts in_data this cycle
//   mem_we     loader -> memory   program-memory write enable
//   mem_w_addr loader -> memory   program-memory write address
//   mem_w_data loader -> memory   program-memory write data
//   mem_r_addr loader -> memory   program-memory read address (verify pass)
//   mem_r_data memory -> loader   read data, combinational from mem_r_addr
//
// Modports
//   slave  : the loader side (consumes the byte stream, drives the memory bus)
//   master : the environment side (byte source plus program memory)
// ----------------------------------------------------------------------------
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_w_addr;
    logic [7:0] mem_w_data;
    logic [3:0] mem_r_addr;
    logic [7:0] mem_r_data;

    modport slave (
        input  in_valid, in_data, mem_r_data,
        output in_ready, mem_we, mem_w_addr, mem_w_data, mem_r_addr
    );

    modport master (
        output in_valid, in_data, mem_r_data,
        input  in_ready, mem_we, mem_w_addr, mem_w_data, mem_r_addr
    );
endinterface

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader -- streams NUM_WORDS program bytes into a program memory while
// holding the CPU in reset, optionally reading the memory back to verify an
// XOR checksum.
//
// Parameters
//   NUM_WORDS  bytes loaded per session (1..16)
//
// Ports
//   clk       single clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle request to begin a session (honoured in IDLE/DONE)
//   bus       prog_loader_if.slave: byte stream in, memory write/read bus out
//   cpu_hold  holds the CPU in reset while memory is rewritten
//   busy      session in progress
//   done      last session completed (level, DONE state only)
//   error     verify checksum mismatch, sticky until the next start
//
// Configuration
//   LOADER_VERIFY_EN  when defined, a VERIFY state reads back all NUM_WORDS
//                     addresses and compares their XOR against the checksum
//                     of the accepted bytes. When undefined, FLUSH goes
//                     straight to DONE, mem_r_addr and error are tied to 0.
// ----------------------------------------------------------------------------
module prog_loader #(
    parameter int NUM_WORDS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         error
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY, DONE} state_e;
`else
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DONE} state_e;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;        // index of the next byte to accept
    logic [7:0] csum_q, csum_d;      // XOR of all accepted bytes
    logic       we_q, we_d;
    logic [3:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;

`ifdef LOADER_VERIFY_EN
    logic [3:0] raddr_q, raddr_d;
    logic [7:0] rsum_q, rsum_d;      // XOR of bytes read back so far
    logic       error_q, error_d;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;              // write strobe is a single-cycle pulse
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef LOADER_VERIFY_EN
        raddr_d = raddr_q;
        rsum_d  = rsum_q;
        error_d = error_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    csum_d  = '0;
`ifdef LOADER_VERIFY_EN
                    raddr_d = '0;
                    rsum_d  = '0;
                    error_d = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    we_d    = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = bus.in_data;
                    csum_d  = csum_q ^ bus.in_data;
                    // The index stops at the last word rather than wrapping,
                    // so address 0 can never be rewritten within a session.
                    if (idx_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FLUSH: begin
                // The registered write of the last byte is on the bus now.
`ifdef LOADER_VERIFY_EN
                state_d = VERIFY;
`else
                state_d = DONE;
`endif
            end
`ifdef LOADER_VERIFY_EN
            VERIFY: begin
                rsum_d = rsum_q ^ bus.mem_r_data;
                if (raddr_q == LAST_IDX) begin
                    error_d = (rsum_d != csum_q);
                    state_d = DONE;
                end else begin
                    raddr_d = raddr_q + 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef LOADER_VERIFY_EN
            raddr_q <= '0;
            rsum_q  <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_VERIFY_EN
            raddr_q <= raddr_d;
            rsum_q  <= rsum_d;
            error_q <= error_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.mem_we     = we_q;
    assign bus.mem_w_addr = waddr_q;
    assign bus.mem_w_data = wdata_q;
    assign done           = (state_q == DONE);

`ifdef LOADER_VERIFY_EN
    assign busy           = (state_q == LOAD) || (state_q == FLUSH) || (state_q == VERIFY);
    assign bus.mem_r_addr = raddr_q;
    assign error          = error_q;
`else
    logic unused_r_data;
    assign unused_r_data  = ^bus.mem_r_data;
    assign busy           = (state_q == LOAD) || (state_q == FLUSH);
    assign bus.mem_r_addr = '0;
    assign error          = 1'b0;
`endif

    assign cpu_hold = busy;

endmodule

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader -- directed testbench for prog_loader. Two instances are
// used: u_dut16 (NUM_WORDS=16) and u_dut6 (NUM_WORDS=6), each with its own
// interface, byte source and program-memory model. Build with or without
// LOADER_VERIFY_EN; expectations follow the macro.
// ----------------------------------------------------------------------------
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start16, start6;
    logic cpu_hold16, busy16, done16, error16;
    logic cpu_hold6, busy6, done6, error6;
    logic corrupt16;

    logic [7:0]  mem16 [16];
    logic [7:0]  mem6  [16];
    logic [11:0] wq16 [$];           // observed writes {addr, data}
    logic [11:0] wq6  [$];

    int n_checks = 0;
    int n_errors = 0;

    prog_loader_if if16 ();
    prog_loader_if if6 ();

    prog_loader #(.NUM_WORDS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .bus(if16.slave),
        .cpu_hold(cpu_hold16), .busy(busy16), .done(done16), .error(error16)
    );

    prog_loader #(.NUM_WORDS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .bus(if6.slave),
        .cpu_hold(cpu_hold6), .busy(busy6), .done(done6), .error(error6)
    );

    always #5 clk = ~clk;

    // Memory models: combinational read, optional corruption of address 3.
    assign if16.mem_r_data = (corrupt16 && if16.mem_r_addr == 4'd3) ? 8'hFF : mem16[if16.mem_r_addr];
    assign if6.mem_r_data  = mem6[if6.mem_r_addr];

    // Writes are captured on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (if16.mem_we) begin
            mem16[if16.mem_w_addr] = if16.mem_w_data;
            wq16.push_back({if16.mem_w_addr, if16.mem_w_data});
        end
        if (if6.mem_we) begin
            mem6[if6.mem_w_addr] = if6.mem_w_data;
            wq6.push_back({if6.mem_w_addr, if6.mem_w_data});
        end
    end

`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    localparam logic [7:0] B6 [6] = '{8'hA1, 8'h78, 8'h66, 8'h08, 8'h61, 8'h91};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse16();
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        check("start16_busy", {busy16, cpu_hold16, done16, if16.in_ready}, 4'b1101);
    endtask

    // Streams 16 back-to-back bytes base+i; start is raised alongside byte mid.
    task automatic load16(input logic [7:0] base, input int mid);
        for (int i = 0; i < 16; i++) begin
            if16.in_valid = 1'b1;
            if16.in_data  = base + 8'(i);
            start16       = (i == mid);
            tick();
            check($sformatf("wr16_%0d", i), {if16.mem_we, if16.mem_w_addr, if16.mem_w_data},
                  {1'b1, 4'(i), 8'(base + 8'(i))});
        end
        if16.in_valid = 1'b0;
        start16       = 1'b0;
    endtask

    task automatic check_wq16(input string tag, input logic [7:0] base);
        check({tag, "_count"}, wq16.size(), 16);
        for (int i = 0; i < 16 && i < wq16.size(); i++)
            check($sformatf("%s_%0d", tag, i), wq16[i], {4'(i), 8'(base + 8'(i))});
    endtask

    task automatic wait_done(input string tag, input bit use6, input int budget);
        int n = 0;
        while (!(use6 ? done6 : done16) && n < budget) begin
            tick();
            n++;
        end
        check(tag, use6 ? done6 : done16, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem16[i] = 8'h00;
            mem6[i]  = 8'h00;
        end
        rst_n         = 1'b0;
        start16       = 1'b0;
        start6        = 1'b0;
        corrupt16     = 1'b0;
        if16.in_valid = 1'b1;
        if16.in_data  = 8'h55;
        if6.in_valid  = 1'b0;
        if6.in_data   = 8'h00;

        // Reset with in_valid high: everything quiet, nothing accepted.
        repeat (3) tick();
        check("rst_outputs", {if16.in_ready, if16.mem_we, if16.mem_w_addr, if16.mem_w_data,
                              if16.mem_r_addr, cpu_hold16, busy16, done16, error16}, '0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_ready", {if16.in_ready, busy16, cpu_hold16, done16}, 4'b0000);
        check("idle_no_write", wq16.size(), 0);

        // start together with in_valid from IDLE: byte 0xAA must not be taken.
        if16.in_data = 8'hAA;
        start_pulse16();
        load16(8'h00, -1);
        check("flush16", {busy16, cpu_hold16, done16}, 3'b110);
        tick();
`ifdef LOADER_VERIFY_EN
        check("verify_entry", {busy16, done16, if16.mem_we}, 3'b100);
        repeat (15) tick();
        check("verify_last", done16, 1'b0);
        tick();
`endif
        check("done16", {done16, busy16, cpu_hold16, error16}, 4'b1000);
        check_wq16("seq", 8'h00);

        // start mid-LOAD at byte 8 is ignored; a single completed session.
        wq16.delete();
        start_pulse16();
        load16(8'h10, 8);
        wait_done("mid_done", 1'b0, 40);
        repeat (2) tick();
        check("mid_stays_done", {done16, busy16}, 2'b10);
        check_wq16("mid", 8'h10);

        // Corrupted read-back at address 3 flags error only in verify builds.
        wq16.delete();
        corrupt16 = 1'b1;
        start_pulse16();
        load16(8'h40, -1);
        wait_done("err_done", 1'b0, 40);
        check("err_flag", error16, VERIFY_EN);
        corrupt16 = 1'b0;
        start_pulse16();
        check("err_cleared", {error16, done16}, 2'b00);
        load16(8'h50, -1);
        wait_done("clean_done", 1'b0, 40);
        check("clean_error", error16, 1'b0);

        // Reset after 5 of 16 bytes abandons the session immediately.
        start_pulse16();
        for (int i = 0; i < 5; i++) begin
            if16.in_valid = 1'b1;
            if16.in_data  = 8'h20 + 8'(i);
            tick();
        end
        check("pre_rst_we", {if16.mem_we, if16.mem_w_addr}, {1'b1, 4'd4});
        if16.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {busy16, cpu_hold16, if16.mem_we, if16.in_ready, done16}, 5'b00000);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", {busy16, done16, if16.in_ready}, 3'b000);
        wq16.delete();
        start_pulse16();
        load16(8'h30, -1);
        wait_done("reload_done", 1'b0, 40);
        check_wq16("reload", 8'h30);

        // NUM_WORDS=6 with in_valid toggling; trailing bytes must be refused.
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if6.in_valid = 1'b1;
            if6.in_data  = B6[i];
            check($sformatf("ready6_%0d", i), if6.in_ready, 1'b1);
            tick();
            if6.in_valid = 1'b0;
            if6.in_data  = 8'hEE;
            tick();
        end
        if6.in_valid = 1'b1;
        repeat (4) tick();
        check("ready6_after", if6.in_ready, 1'b0);
        if6.in_valid = 1'b0;
        wait_done("done6", 1'b1, 30);
        check("error6", error6, 1'b0);
        check("wq6_count", wq6.size(), 6);
        for (int i = 0; i < 6 && i < wq6.size(); i++)
            check($sformatf("wq6_%0d", i), wq6[i], {4'(i), B6[i]});
        check("mem6_addr6", mem6[6], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter: NUM_WORDS, 16, number of program bytes loaded per session (legal 1..16).
REQ-002 SHALL have ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load session
- in_valid  input  1  byte-stream source has data
- in_data  input  8  program byte
- in_ready  output  1  loader accepts in_data this cycle
- mem_we  output  1  program-memory write enable
- mem_w_addr  output  4  program-memory write address
- mem_w_data  output  8  program-memory write data
- mem_r_addr  output  4  program-memory read address (verify pass)
- mem_r_data  input  8  program-memory read data, combinational from mem_r_addr
- cpu_hold  output  1  holds the CPU in reset while memory is rewritten
- busy  output  1  session in progress
- done  output  1  last session completed
- error  output  1  verify checksum mismatch, sticky

Function
REQ-003 SHALL implement states IDLE, LOAD, FLUSH, VERIFY, DONE.
REQ-004 IDLE/DONE: start=1 -> LOAD; word counter and checksum cleared; done and error cleared.
REQ-005 LOAD: in_ready=1 combinationally; in_ready=0 in every other state.
REQ-006 Handshake: byte transferred on a rising edge with in_valid && in_ready; one byte per cycle maximum; in_valid without in_ready transfers nothing.
REQ-007 Byte accepted in cycle T SHALL appear as mem_we=1, mem_w_addr=word index, mem_w_data=byte in cycle T+1 only (registered, single-cycle pulse per byte).
REQ-008 Word index starts at 0, increments by 1 per accepted byte; accepting index NUM_WORDS-1 moves state to FLUSH; index never wraps, address 0 never rewritten in the same session.
REQ-009 FLUSH lasts exactly one cycle (final mem_we pulse), then VERIFY if enabled (REQ-017) else DONE.
REQ-010 Checksum: 8-bit XOR of all accepted bytes, updated on each handshake.
REQ-011 cpu_hold=1 and busy=1 in LOAD, FLUSH, VERIFY; both 0 in IDLE and DONE.
REQ-012 done=1 as a level in DONE only.
REQ-013 start in LOAD, FLUSH or VERIFY SHALL be ignored; start in DONE begins a fresh session.
REQ-014 start and in_valid in the same cycle from IDLE: start honoured, byte not accepted (in_ready was 0).
REQ-015 mem_we SHALL be 0 in IDLE, VERIFY, DONE.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, in_ready=0, mem_we=0, mem_w_addr=0, mem_w_data=0, mem_r_addr=0, cpu_hold=0, busy=0, done=0, error=0, counters/checksum 0; a session interrupted by reset is abandoned (partial memory contents left as written).

Configuration
REQ-017 Macro LOADER_VERIFY_EN defined: VERIFY state walks mem_r_addr 0..NUM_WORDS-1 one address per cycle, XORs mem_r_data into a read checksum, then sets error=1 if read checksum != write checksum, and enters DONE (NUM_WORDS cycles in VERIFY).
REQ-018 Macro LOADER_VERIFY_EN undefined: VERIFY state absent, FLUSH -> DONE, mem_r_addr tied 0, mem_r_data unused, error tied 0.

Verification
REQ-019 Reset with in_valid=1, start=0 -> all outputs 0, no mem_we, in_ready=0 indefinitely.
REQ-020 start, then 16 back-to-back bytes 0x00..0x0F -> mem_we pulses addr 0..15 with data 0x00..0x0F one cycle after each handshake; done=1 and cpu_hold=0 after FLUSH (+16 cycles with LOADER_VERIFY_EN); error=0.
REQ-021 NUM_WORDS=6, bytes A1,78,66,08,61,91 with in_valid toggled every other cycle -> exactly 6 writes to addr 0..5, no write to addr 6, done=1.
REQ-022 LOADER_VERIFY_EN, memory model corrupts addr 3 (reads 0xFF) -> error=1 with done=1; next start clears error.
REQ-023 Assert rst_n low after 5 of 16 bytes -> immediate IDLE, cpu_hold=0, mem_we=0; subsequent start reloads from addr 0.
REQ-024 start pulsed mid-LOAD at byte 8 -> ignored, index continues 9..15, single done.
